// File: rtl/btn_move_sched_pkg.sv
// Shared definitions for the button-to-paddle movement sequencer.
package btn_move_sched_pkg;

    // Resolved per-player movement direction.
    typedef enum logic [1:0] {
        DirNone = 2'b00,
        DirUp   = 2'b01,
        DirDown = 2'b10
    } dir_e;

    // Width of the hold counter, which saturates at (max_steps-1) << accel_shift.
    function automatic int unsigned hold_width(input int unsigned max_steps,
                                               input int unsigned accel_shift);
        int unsigned hold_max;
        hold_max = (max_steps - 1) << accel_shift;
        return (hold_max < 1) ? 1 : $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/btn_move_chan.sv
// One player: synchronise and debounce up/down, resolve direction and
// schedule a per-frame burst of one-cycle step pulses that grows while held.
module btn_move_chan
    import btn_move_sched_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 50000,
    parameter int unsigned ACCEL_SHIFT = 3,
    parameter int unsigned MAX_STEPS   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic pause,
    input  logic up_raw,
    input  logic down_raw,
    output logic step_up,
    output logic step_down
);

    localparam int unsigned CntW    = $clog2(DEB_CYCLES);
    localparam int unsigned HoldW   = hold_width(MAX_STEPS, ACCEL_SHIFT);
    localparam int unsigned HoldMax = (MAX_STEPS - 1) << ACCEL_SHIFT;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]      sync1_q, sync2_q, deb_q;
    logic [CntW-1:0] cnt_q [2];

    dir_e             dir, prev_dir_q, burst_dir_q;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [3:0]       burst_q, load, n_steps;
    logic [31:0]      hold_sh;
    logic             up_q, down_q;

    // Two-flop synchronisers feeding a consecutive-mismatch debouncer per button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= {down_raw, up_raw};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntW'(DEB_CYCLES - 1)) begin
                    deb_q[i] <= ~deb_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Direction resolve and next burst length / hold for a frame tick.
    always_comb begin
        case (deb_q)
            2'b01:   dir = DirUp;
            2'b10:   dir = DirDown;
            default: dir = DirNone;
        endcase

        hold_sh = 32'(hold_q) >> ACCEL_SHIFT;
        if (hold_sh >= MAX_STEPS - 1) n_steps = 4'(MAX_STEPS);
        else                          n_steps = 4'(hold_sh + 1);

        load   = '0;
        hold_d = '0;
        if (dir == DirNone) begin
            load   = '0;
            hold_d = '0;
        end else if (dir != prev_dir_q) begin
            load   = 4'd1;
            hold_d = HoldW'(1);
        end else begin
            load   = n_steps;
            hold_d = (32'(hold_q) < HoldMax) ? hold_q + 1'b1 : hold_q;
        end
    end

    // Burst scheduler; the first pulse of a burst is launched on the tick edge,
    // so burst_q counts the pulses still owed after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dir_q  <= DirNone;
            burst_dir_q <= DirNone;
            hold_q      <= '0;
            burst_q     <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end else if (frame_tick && !pause) begin
            prev_dir_q  <= dir;
            burst_dir_q <= dir;
            hold_q      <= hold_d;
            up_q        <= (load != 4'd0) && (dir == DirUp);
            down_q      <= (load != 4'd0) && (dir == DirDown);
            burst_q     <= (load != 4'd0) ? load - 4'd1 : 4'd0;
        end else if (burst_q != 4'd0) begin
            up_q        <= (burst_dir_q == DirUp);
            down_q      <= (burst_dir_q == DirDown);
            burst_q     <= burst_q - 4'd1;
        end else begin
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end
    end

    assign step_up   = up_q;
    assign step_down = down_q;

endmodule

// File: rtl/btn_move_sched.sv
// Top level: two independent player channels between raw buttons and paddles.
module btn_move_sched
    import btn_move_sched_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 50000,
    parameter int unsigned ACCEL_SHIFT = 3,
    parameter int unsigned MAX_STEPS   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic pause,
    input  logic btn1_up_raw,
    input  logic btn1_down_raw,
    input  logic btn2_up_raw,
    input  logic btn2_down_raw,
    output logic ply1_up,
    output logic ply1_down,
    output logic ply2_up,
    output logic ply2_down
);

    btn_move_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .ACCEL_SHIFT (ACCEL_SHIFT),
        .MAX_STEPS   (MAX_STEPS)
    ) u_chan1 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pause      (pause),
        .up_raw     (btn1_up_raw),
        .down_raw   (btn1_down_raw),
        .step_up    (ply1_up),
        .step_down  (ply1_down)
    );

    btn_move_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .ACCEL_SHIFT (ACCEL_SHIFT),
        .MAX_STEPS   (MAX_STEPS)
    ) u_chan2 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pause      (pause),
        .up_raw     (btn2_up_raw),
        .down_raw   (btn2_down_raw),
        .step_up    (ply2_up),
        .step_down  (ply2_down)
    );

endmodule

// File: tb/tb_btn_move_sched.sv
// Directed scenarios plus random stimulus, checked against a behavioural model.
module tb_btn_move_sched;

    localparam int unsigned DEB     = 4;
    localparam int unsigned ASH     = 1;
    localparam int unsigned MAXS    = 3;
    localparam int          HOLDMAX = (MAXS - 1) << ASH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, frame_tick = 1'b0, pause = 1'b0;
    logic btn1_up_raw = 1'b0, btn1_down_raw = 1'b0, btn2_up_raw = 1'b0, btn2_down_raw = 1'b0;
    logic ply1_up, ply1_down, ply2_up, ply2_down;

    btn_move_sched #(
        .DEB_CYCLES  (DEB),
        .ACCEL_SHIFT (ASH),
        .MAX_STEPS   (MAXS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .pause         (pause),
        .btn1_up_raw   (btn1_up_raw),
        .btn1_down_raw (btn1_down_raw),
        .btn2_up_raw   (btn2_up_raw),
        .btn2_down_raw (btn2_down_raw),
        .ply1_up       (ply1_up),
        .ply1_down     (ply1_down),
        .ply2_up       (ply2_up),
        .ply2_down     (ply2_down)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: buttons 0..3 = p1 up, p1 down, p2 up, p2 down.
    // Directions: 0 none, 1 up, 2 down.
    int m_s1 [4], m_s2 [4], m_deb [4], m_run [4];
    int m_prev [2], m_hold [2], m_pend [2], m_bdir [2];
    logic [3:0] exp_out = '0;
    int cnt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        logic [3:0] raw;
        int d, n;
        raw = {btn2_down_raw, btn2_up_raw, btn1_down_raw, btn1_up_raw};
        exp_out = '0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                m_prev[p] = 0; m_hold[p] = 0; m_pend[p] = 0; m_bdir[p] = 0;
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if (m_deb[2*p] == 1 && m_deb[2*p+1] == 0)      d = 1;
            else if (m_deb[2*p+1] == 1 && m_deb[2*p] == 0) d = 2;
            else                                           d = 0;
            if (frame_tick && !pause) begin
                n = 1 + (((m_hold[p] >> ASH) < MAXS - 1) ? (m_hold[p] >> ASH) : MAXS - 1);
                if (d == 0) begin
                    m_pend[p] = 0; m_hold[p] = 0;
                end else if (d != m_prev[p]) begin
                    m_pend[p] = 1; m_hold[p] = 1;
                end else begin
                    m_pend[p] = n;
                    m_hold[p] = (m_hold[p] + 1 > HOLDMAX) ? HOLDMAX : m_hold[p] + 1;
                end
                m_prev[p] = d;
                m_bdir[p] = d;
            end
            if (m_pend[p] > 0) begin
                exp_out[2*p + m_bdir[p] - 1] = 1'b1;
                m_pend[p]--;
            end
        end
        // A level is accepted after DEB consecutive disagreeing synchronised samples.
        for (int i = 0; i < 4; i++) begin
            m_run[i] = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DEB) begin
                m_deb[i] = 1 - m_deb[i];
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(raw[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("outputs", 32'({ply2_down, ply2_up, ply1_down, ply1_up}), 32'(exp_out));
        cnt[0] += int'(ply1_up);
        cnt[1] += int'(ply1_down);
        cnt[2] += int'(ply2_up);
        cnt[3] += int'(ply2_down);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One frame: a single-cycle tick followed by 19 idle cycles, pulses counted.
    task automatic frame();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        idle(19);
    endtask

    int acc_exp [6] = '{1, 1, 2, 2, 3, 3};
    int rev_exp [5] = '{1, 1, 2, 2, 3};

    initial begin
        // Reset, then a 3-cycle glitch that must not be accepted.
        idle(3);
        rst = 1'b0;
        btn1_up_raw = 1'b1;
        idle(3);
        btn1_up_raw = 1'b0;
        idle(8);
        frame();
        check("glitch_up", 32'(cnt[0]), 32'd0);
        check("glitch_down", 32'(cnt[1]), 32'd0);

        // Steady hold and acceleration, then reversal.
        btn1_up_raw = 1'b1;
        idle(8);
        for (int k = 0; k < 6; k++) begin
            frame();
            check("accel_up", 32'(cnt[0]), 32'(acc_exp[k]));
            check("accel_down", 32'(cnt[1]), 32'd0);
        end
        btn1_up_raw   = 1'b0;
        btn1_down_raw = 1'b1;
        idle(8);
        for (int k = 0; k < 5; k++) begin
            frame();
            check("rev_down", 32'(cnt[1]), 32'(rev_exp[k]));
            check("rev_up", 32'(cnt[0]), 32'd0);
        end

        // Pause with hold = 3.
        btn1_down_raw = 1'b0;
        idle(8);
        frame();
        check("release", 32'(cnt[1]), 32'd0);
        btn1_up_raw = 1'b1;
        idle(8);
        repeat (3) frame();
        check("pre_pause", 32'(cnt[0]), 32'd2);
        pause = 1'b1;
        repeat (2) begin
            frame();
            check("paused", 32'(cnt[0]), 32'd0);
        end
        pause = 1'b0;
        frame();
        check("post_pause", 32'(cnt[0]), 32'd2);

        // Conflict on player 2.
        btn2_up_raw   = 1'b1;
        btn2_down_raw = 1'b1;
        idle(8);
        repeat (2) begin
            frame();
            check("conflict", 32'(cnt[2] + cnt[3]), 32'd0);
        end
        btn2_down_raw = 1'b0;
        idle(8);
        frame();
        check("conflict_rel", 32'(cnt[2]), 32'd1);

        // Tick one cycle after a 3-pulse burst starts: 1 old + 3 new pulses.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        idle(18);
        check("overlap", 32'(cnt[0]), 32'd4);

        // Reset mid-burst.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rst_mid", 32'(ply1_up), 32'd0);
        rst = 1'b0;
        idle(8);
        frame();
        check("after_rst", 32'(cnt[0]), 32'd1);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) btn1_up_raw   = ~btn1_up_raw;
            if ($urandom_range(0, 39) == 0) btn1_down_raw = ~btn1_down_raw;
            if ($urandom_range(0, 39) == 0) btn2_up_raw   = ~btn2_up_raw;
            if ($urandom_range(0, 39) == 0) btn2_down_raw = ~btn2_down_raw;
            if ($urandom_range(0, 149) == 0) pause = ~pause;
            frame_tick = (i % 20 == 0) || ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 799) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_move_sched.md
Name: btn_move_sched

Overview:
- Sequencer between the raw player push-buttons and the paddle position registers.
- Synchronises and debounces the four buttons and resolves up/down conflicts per player.
- Once per video frame, issues a burst of one-cycle step pulses (ply*_up / ply*_down) to the paddle position block.
- The burst length grows while a direction is held, so paddles accelerate.

Parameters:
- DEB_CYCLES, 50000: consecutive stable synchronised samples required to accept a button level (>=2).
- ACCEL_SHIFT, 3: frames held per acceleration step = 2^ACCEL_SHIFT.
- MAX_STEPS, 4: maximum pulses per frame per player (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- pause  in  1  level; freezes movement scheduling
- btn1_up_raw, btn1_down_raw, btn2_up_raw, btn2_down_raw  in  1 each  asynchronous raw buttons, active-high
- ply1_up, ply1_down, ply2_up, ply2_down  out  1 each  registered one-cycle step pulses to the paddle position block

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high.
- Reset: all outputs 0. Synchronisers, debounced levels, debounce counters, hold counters and burst counters all 0. Reset asserted mid-burst: pulses are 0 from the next edge onward.
- Per button: 2-FF synchroniser, then debouncer.
  - Debouncer counts consecutive cycles where the synchronised value != the debounced value.
  - Counter resets to 0 on any match.
  - On reaching DEB_CYCLES: debounced value toggles and the counter clears.
- Raw-to-debounced latency: 2 + DEB_CYCLES cycles for a clean edge.
- Direction per player: dir = UP if up&!down, DOWN if down&!up, NONE otherwise (both pressed = NONE).
- Per player state: prev_dir, hold (width sized to saturate at (MAX_STEPS-1)<<ACCEL_SHIFT), burst (4 bits), burst_dir.
- On frame_tick=1 with pause=0, sampled at cycle t:
  - n = 1 + min(hold>>ACCEL_SHIFT, MAX_STEPS-1), using the pre-update hold.
  - dir==NONE: burst<=0, hold<=0.
  - dir!=prev_dir: burst<=1, hold<=1.
  - Otherwise: burst<=n, hold<=hold+1, saturating.
  - prev_dir<=dir in all cases. burst_dir<=dir.
- Emission:
  - While burst>0, drive the pulse for burst_dir high and decrement burst.
  - Pulses appear in cycles t+1 .. t+burst, consecutive, registered.
- Up and down pulses of one player are never high in the same cycle. Players are fully independent.
- frame_tick during an active burst: the remaining pulses are abandoned and the new burst is loaded per the rules above.
- pause=1:
  - frame_tick is ignored.
  - hold and prev_dir are frozen.
  - An in-flight burst completes.
  - Debouncers keep running.
- A frame_tick wider than 1 cycle is treated as a tick every cycle it is high (not filtered).

Decomposition:
- Shared package holds:
  - dir encoding constants: NONE=2'b00, UP=2'b01, DOWN=2'b10.
  - The function computing hold width from MAX_STEPS and ACCEL_SHIFT.
- Natural sub-module: btn_move_chan (one player: 2 synchronisers, 2 debouncers, dir resolve, hold/burst logic), instantiated twice.
- Top level holds only wiring.

Test Plan:
All scenarios use DEB_CYCLES=4, ACCEL_SHIFT=1, MAX_STEPS=3, and frame_tick every 20 cycles.
- Reset and debounce.
  - Stimulus: rst for 3 cycles, then btn1_up_raw=1 glitching for 3 cycles then low.
  - Required: all outputs 0 throughout; debounced level never changes.
- Steady hold and acceleration.
  - Stimulus: btn1_up_raw held high.
  - Required: ply1_up pulse counts on successive ticks are 1,1,2,2,3,3,3… Pulses are consecutive starting the cycle after the tick. ply1_down stays 0.
- Conflict.
  - Stimulus: btn2_up_raw and btn2_down_raw both held high.
  - Required: zero pulses on ply2_*. On release of down, the next tick gives exactly 1 ply2_up pulse (hold restarted).
- Direction reversal.
  - Stimulus: after 6 ticks of up on player 1, switch to down.
  - Required: first down tick gives 1 ply1_down pulse, then 1,2,2,3…
- Pause.
  - Stimulus: set pause=1 mid-hold (hold=3) across 2 ticks.
  - Required: no pulses on those ticks. After pause=0, the next tick emits 2 pulses (hold still 3).
- Overlap and reset.
  - Stimulus: frame_tick 1 cycle after a 3-pulse burst starts.
  - Required: exactly 1 old pulse, then the new burst.
  - Stimulus: rst asserted mid-burst.
  - Required: pulses stop the next cycle; the following tick after rst deassertion gives 1 pulse.
